// File: rtl/dec_nx2n_bist.sv
// Registered N-to-2^N one-hot decoder with single-bit stuck-at fault injection
// and a built-in self-test sweep that reports pass, mismatch count and first failing code.
module dec_nx2n_bist #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      A,
    input  logic              start,
    input  logic              flt_en,
    input  logic [N-1:0]      flt_idx,
    input  logic              flt_val,
    output logic [2**N-1:0]   D,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N:0]        err_cnt,
    output logic [N-1:0]      first_fail
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   cnt;
    logic           sweeping;
    logic           last_code;
    logic [N-1:0]   core_code;
    logic           core_en;
    logic [W-1:0]   raw_f;
    logic [W-1:0]   golden;
    logic           mismatch;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SWEEP;
            S_SWEEP: if (last_code) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_SWEEP);
        done = (state == S_DONE);
    end

    assign sweeping  = (state == S_SWEEP);
    assign last_code = (cnt == {N{1'b1}});

    // Core decode: the sweep counter owns the decoder while sweeping
    always_comb begin
        core_code = sweeping ? cnt : A;
        core_en   = sweeping | en;
        raw_f     = '0;
        if (core_en) raw_f[core_code] = 1'b1;
        if (flt_en)  raw_f[flt_idx]   = flt_val;
    end

    always_comb begin
        golden      = '0;
        golden[cnt] = 1'b1;
        mismatch    = (raw_f != golden);
    end

    // Output register and sweep bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            D          <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            D <= raw_f;
            if (state == S_IDLE && start) begin
                cnt        <= '0;
                err_cnt    <= '0;
                first_fail <= '0;
                pass       <= 1'b0;
            end
            if (sweeping) begin
                if (mismatch) begin
                    err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == '0) first_fail <= cnt;
                end
                // pass must already be valid in the DONE cycle, so fold in the last compare
                if (last_code) pass <= (err_cnt == '0) && !mismatch;
                else           cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_nx2n_bist.sv
// Randomized and directed bench for dec_nx2n_bist (N=4) against a cycle-level
// behavioural model of the decode and sweep rules.
module tb_dec_nx2n_bist;

    logic        clk = 1'b0;
    logic        rst, en, start, flt_en, flt_val;
    logic [3:0]  A, flt_idx;
    logic [15:0] D;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: phase 0 = idle, 1 = sweeping, 2 = reporting
    int          m_phase;
    int          m_code;
    logic [15:0] m_D;
    int          m_err;
    int          m_ff;
    bit          m_pass;

    dec_nx2n_bist #(.N(4)) dut (
        .clk(clk), .rst(rst), .en(en), .A(A), .start(start),
        .flt_en(flt_en), .flt_idx(flt_idx), .flt_val(flt_val),
        .D(D), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] fdec(input int code, input bit e);
        logic [15:0] v;
        v = e ? (16'h0001 << code) : 16'h0000;
        if (flt_en) v[flt_idx] = flt_val;
        return v;
    endfunction

    task automatic model_step();
        logic [15:0] v;
        if (rst) begin
            m_phase = 0; m_code = 0; m_D = '0; m_err = 0; m_ff = 0; m_pass = 0;
        end else if (m_phase == 1) begin
            v = fdec(m_code, 1'b1);
            m_D = v;
            if (v != (16'h0001 << m_code)) begin
                if (m_err == 0) m_ff = m_code;
                m_err++;
            end
            if (m_code == 15) begin
                m_phase = 2;
                m_pass  = (m_err == 0);
            end else begin
                m_code++;
            end
        end else begin
            m_D = fdec(int'(A), en);
            if (m_phase == 2) m_phase = 0;
            else if (start) begin
                m_phase = 1; m_code = 0; m_err = 0; m_ff = 0; m_pass = 0;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("D", D, m_D);
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("pass", pass, m_pass);
        chk("err_cnt", err_cnt, m_err);
        if (!m_pass) chk("first_fail", first_fail, m_ff);
    endtask

    task automatic run_sweep(input bit poke);
        int n;
        bit seen;
        n = 40;
        seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            start = poke && (i == 4);
            step();
            if (done === 1'b1) begin
                seen = 1;
                n = i + 1;
            end
        end
        start = 1'b0;
        chk("sweep_len", n, 16);
        step();
        chk("done_single", done, 1'b0);
    endtask

    initial begin
        rst = 1; en = 0; start = 0; flt_en = 0; flt_val = 0; A = 0; flt_idx = 0;
        step();
        step();
        chk("rst_D", D, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_cnt, 5'd0);
        rst = 0;

        // normal decode
        en = 1;
        for (int i = 0; i < 16; i++) begin
            A = 4'(i);
            step();
            chk("norm_D", D, 16'h0001 << i);
        end
        en = 0;
        step();
        chk("en0_D", D, 16'h0000);

        // clean sweep, with a stray start mid-sweep
        run_sweep(1'b1);
        chk("clean_pass", pass, 1'b1);
        chk("clean_err", err_cnt, 5'd0);

        // SA0 on bit 5
        flt_en = 1; flt_idx = 4'd5; flt_val = 0;
        run_sweep(1'b0);
        chk("sa0_pass", pass, 1'b0);
        chk("sa0_err", err_cnt, 5'd1);
        chk("sa0_ff", first_fail, 4'd5);
        en = 1; A = 4'd5;
        step();
        chk("sa0_norm", D, 16'h0000);

        // SA1 on bit 0
        flt_idx = 4'd0; flt_val = 1; en = 0;
        run_sweep(1'b0);
        chk("sa1_err", err_cnt, 5'd15);
        chk("sa1_ff", first_fail, 4'd1);
        chk("sa1_pass", pass, 1'b0);
        step();
        chk("sa1_norm", D, 16'h0001);

        // reset during sweep
        flt_en = 0;
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 7; i++) step();
        rst = 1;
        step();
        rst = 0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_D", D, 16'h0000);
        chk("abort_err", err_cnt, 5'd0);
        chk("abort_done", done, 1'b0);
        step();
        chk("abort_nodone", done, 1'b0);
        run_sweep(1'b0);
        chk("after_abort_pass", pass, 1'b1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            A       = 4'($urandom_range(0, 15));
            en      = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) begin
                flt_en  = 1'($urandom_range(0, 1));
                flt_idx = 4'($urandom_range(0, 15));
                flt_val = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_nx2n_bist.md
Name: dec_nx2n_bist

Overview:
- Parametrised registered N-to-2^N one-hot decoder with an enable, stuck-at fault injection on any single output bit, and a built-in self-test (BIST) sweep.
- The sweep applies every input code, compares each result against a golden one-hot value, then reports pass/fail, the mismatch count and the first failing code.
- Successor to the fixed 4-to-16 faulted decoders. It is used as a self-checking decode stage and as the reference target for fault-coverage experiments.

Parameters:
- N, 4, input code width; output width is 2**N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  decode enable in normal mode.
- A  input  N  input code in normal mode.
- start  input  1  single-cycle pulse that launches a BIST sweep.
- flt_en  input  1  enables fault injection.
- flt_idx  input  N  output bit index that receives the stuck-at fault.
- flt_val  input  1  stuck-at value: 0 = SA0, 1 = SA1.
- D  output  2**N  registered decoder output.
- busy  output  1  high while the sweep is running.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  sweep result; held until the next start.
- err_cnt  output  N+1  number of mismatching codes in the last sweep.
- first_fail  output  N  lowest code that mismatched in the last sweep.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: D=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0. FSM returns to IDLE and the sweep counter clears to 0.
- Core decode (combinational):
  - raw[i] = core_en & (core_code == i).
  - If flt_en=1, bit flt_idx of raw is forced to flt_val.
  - Fault injection applies in every mode. Changes to flt_* take effect in the same cycle.
- Normal mode (IDLE state):
  - core_code = A, core_en = en.
  - D <= faulted raw on each edge, so latency is 1 cycle.
  - en=0 gives D=0 unless the injected fault is SA1.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on start=1. On that edge: cnt<=0, err_cnt<=0, first_fail<=0, pass<=0, busy<=1.
  - SWEEP, each cycle:
    - core_code = cnt, core_en = 1; A and en are ignored.
    - D <= faulted raw, so D shows the sweep pattern one cycle behind.
    - Compare faulted raw against golden (1 << cnt) in the same cycle.
    - On a mismatch, err_cnt increments. If this is the first mismatch of the sweep, first_fail <= cnt.
    - If cnt == 2**N-1, go to DONE; otherwise cnt <= cnt+1.
  - SWEEP lasts exactly 2**N cycles.
  - DONE, for one cycle: done=1, busy=0, pass=(err_cnt==0). Next state is IDLE.
- Start handling: start is ignored in SWEEP and in DONE. A start in the first IDLE cycle after DONE launches a new sweep.
- Held results: err_cnt, first_fail and pass hold after DONE until the next start or reset. first_fail is meaningful only when pass=0.
- Width rule: err_cnt never wraps, since its maximum of 2**N fits in N+1 bits.
- Reset mid-sweep: the sweep aborts, all outputs return to reset values, and done is not pulsed.
- A fault change mid-sweep affects only the codes applied after the change.

Test Plan (N=4):
- Normal decode, flt_en=0, en=1, A=0..15 one per cycle -> one cycle later D=16'h0001<<A each cycle. en=0 -> D=16'h0000.
- Clean BIST, flt_en=0, start pulse -> busy=1 for 16 cycles, done pulses on the 17th cycle after start, pass=1, err_cnt=0.
- SA0 on bit 5 (flt_en=1, flt_idx=5, flt_val=0), start -> pass=0, err_cnt=1, first_fail=5. In normal mode with A=5, en=1 -> D=16'h0000.
- SA1 on bit 0, start -> err_cnt=15, first_fail=1, pass=0. In normal mode with en=0 -> D=16'h0001.
- start pulsed again mid-sweep -> ignored: the sweep still completes after 16 cycles with a single done pulse.
- rst asserted at sweep cycle 7 -> next cycle busy=0, D=0, err_cnt=0, no done pulse. A subsequent start gives a full 16-cycle sweep.
